score_tracker: RTL and testbench
================================

Name: score_tracker

Overview:
- Parametrised scoring engine for the FPGA guitar-hero game.
- Replaces the level-compare point counter with per-note judgement:
  - N lanes
  - rising-edge press detection and chord support
  - a miss on timeout or a wrong lane
  - combo counter and multiplier
  - saturating score
- Sits between the song ROM sequencer, which supplies song_data and a note-step tick, and the score display/seven-segment driver.

Parameters:
- LANES, 4, number of button lanes / note bits
- SCORE_W, 16, score width
- COMBO_W, 8, combo counter width
- POINTS_PER_HIT, 10, base points per judged hit
- COMBO_STEP, 8, consecutive hits per multiplier step
- MAX_MULT, 4, multiplier ceiling

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- tick  in  1  one-cycle strobe at each note-step boundary
- clear  in  1  synchronous game restart
- buttons  in  LANES  debounced, clk-synchronous button levels
- song_data  in  LANES  note for the step starting at tick; 0 = rest
- score  out  SCORE_W  accumulated score
- combo  out  COMBO_W  current consecutive-hit count
- multiplier  out  3  current multiplier, 1..MAX_MULT
- hit  out  1  one-cycle pulse on a judged hit
- miss  out  1  one-cycle pulse on a judged miss

Behaviour:
- Reset values (rst_n low, asynchronous): score=0, combo=0, hit=0, miss=0, state=REST, target=0, pressed=0, btn_q=0.
- multiplier is combinational from combo: min(1 + combo/COMBO_STEP, MAX_MULT).
- clear has the same effect as reset, but synchronous. It has priority over all other events.
- Press detect: new_press = buttons & ~btn_q; btn_q is registered every cycle. Held buttons never re-trigger.
- States:
  - REST: no note active.
  - WINDOW: note active, awaiting judgement.
  - JUDGED: note already scored.
- In WINDOW, each cycle forms acc = pressed | new_press:
  - acc has a bit outside target -> miss; go to JUDGED.
  - else acc == target -> hit; go to JUDGED.
  - else pressed <= acc.
- Wrong-lane check takes priority over the match check in the same cycle.
- On tick, the old note is judged first, using the current cycle's new_press:
  - If WINDOW and not matched this cycle -> miss (timeout).
  - If matched this cycle -> hit.
  - Then target <= song_data and pressed <= 0.
  - Next state = WINDOW if song_data != 0, else REST.
- A tick-cycle judgement and the new note load happen in the same cycle. The new note ignores that cycle's presses.
- Hit:
  - score += POINTS_PER_HIT * multiplier, using the pre-update combo.
  - Score saturates at 2^SCORE_W-1.
  - combo += 1, saturating at 2^COMBO_W-1.
- Miss: combo <= 0; score unchanged.
- Latency: hit/miss/score/combo update at the clk edge that evaluates the condition. The pulses are visible for exactly one cycle after that edge.
- REST and JUDGED: presses are ignored (see Optional Feature). btn_q still tracks buttons.
- At most one of hit/miss per note; never both in one cycle.

Optional Feature:
- Macro: GHOST_PENALTY_EN.
- Defined: any new_press in REST or JUDGED is a ghost note.
  - miss pulses and combo <= 0.
  - score decrements by POINTS_PER_HIT, saturating at 0.
  - The state is unchanged.
  - Ghost presses in the same cycle as a tick are judged against the old state.
- Undefined: such presses are ignored; no extra logic is generated.

Test Plan:
- Reset and defaults: assert rst_n low mid-run with score=50 -> score=0, combo=0, multiplier=1, hit=miss=0 immediately, without waiting for a clk edge.
- Single note: tick with song_data=4'b0010, then buttons=4'b0010 three cycles later -> hit pulses 1 cycle; score=10, combo=1. Holding the button into the next 0010 note gives no hit; that note times out -> miss, combo=0.
- Chord and wrong lane:
  - Note 0101: press bit0, then bit2 two cycles later -> hit after the second press.
  - Next note 0101: press 0111 -> miss; a later correct press gives no hit.
- Multiplier: COMBO_STEP=4, 8 consecutive correct notes -> multiplier 1 for hits 1-4 and 2 for hits 5-8; score=120, combo=8.
- Multiplier cap: continuing to 20 hits -> multiplier=4 from combo 12 onward.
- Tick collision and saturation:
  - Correct press in the same cycle as tick -> hit credited to the old note; new note starts with pressed=0.
  - SCORE_W=8, score=250, multiplier=1 hit -> score=255.
- GHOST_PENALTY_EN: press during a rest with score=30, combo=3 -> miss, score=20, combo=0. Same press with the macro undefined -> no change.

Source files
------------

// File: rtl/score_tracker.sv
// score_tracker: per-note scoring engine for the guitar-hero game.
//
// Detects rising-edge button presses, judges each song note as a hit or a
// miss, and keeps a combo count, a combo multiplier and a saturating score.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   tick       one-cycle strobe at each note-step boundary
//   clear      synchronous game restart (same effect as reset, top priority)
//   buttons    debounced, clk-synchronous button levels, one bit per lane
//   song_data  note for the step starting at tick (0 = rest)
//   score      accumulated score, saturating at all-ones
//   combo      current consecutive-hit count, saturating at all-ones
//   multiplier min(1 + combo/COMBO_STEP, MAX_MULT), combinational from combo
//   hit        one-cycle pulse on a judged hit
//   miss       one-cycle pulse on a judged miss
//
// Optional build macro GHOST_PENALTY_EN: when defined, a new press while no
// note is awaiting judgement (REST or JUDGED) counts as a miss and costs
// POINTS_PER_HIT points (floored at 0). When undefined, such presses are
// ignored and no extra logic is built.
//
// state  | meaning
// REST   | no note active
// WINDOW | note active, awaiting judgement
// JUDGED | note already scored

module score_tracker #(
  parameter int LANES          = 4,
  parameter int SCORE_W        = 16,
  parameter int COMBO_W        = 8,
  parameter int POINTS_PER_HIT = 10,
  parameter int COMBO_STEP     = 8,
  parameter int MAX_MULT       = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic               clear,
  input  logic [LANES-1:0]   buttons,
  input  logic [LANES-1:0]   song_data,
  output logic [SCORE_W-1:0] score,
  output logic [COMBO_W-1:0] combo,
  output logic [2:0]         multiplier,
  output logic               hit,
  output logic               miss
);

  typedef enum logic [1:0] {
    REST   = 2'd0,
    WINDOW = 2'd1,
    JUDGED = 2'd2
  } state_t;

  typedef logic [SCORE_W:0] score_ext_t;

  state_t             state_q,   state_d;
  logic [LANES-1:0]   target_q,  target_d;
  logic [LANES-1:0]   pressed_q, pressed_d;
  logic [LANES-1:0]   btn_q;
  logic [SCORE_W-1:0] score_q,   score_d;
  logic [COMBO_W-1:0] combo_q,   combo_d;
  logic               hit_q,     hit_d;
  logic               miss_q,    miss_d;

  logic [LANES-1:0]   new_press;
  logic [LANES-1:0]   acc;
  logic               wrong_lane;
  logic               matched;
  logic               do_hit;
  logic               do_miss;
  logic [COMBO_W-1:0] combo_steps;
  score_ext_t         hit_points;
  score_ext_t         score_sum;
`ifdef GHOST_PENALTY_EN
  logic               ghost;
`endif

  // Multiplier steps up every COMBO_STEP hits and is clamped at MAX_MULT.
  assign combo_steps = combo_q / COMBO_W'(COMBO_STEP);

  always_comb begin
    if (combo_steps >= COMBO_W'(MAX_MULT - 1)) begin
      multiplier = 3'(MAX_MULT);
    end else begin
      multiplier = 3'(combo_steps) + 3'd1;
    end
  end

  // One extra bit catches overflow so the score can saturate.
  assign hit_points = score_ext_t'(POINTS_PER_HIT) * score_ext_t'(multiplier);
  assign score_sum  = {1'b0, score_q} + hit_points;

  always_comb begin
    new_press  = buttons & ~btn_q;
    acc        = pressed_q | new_press;
    wrong_lane = |(acc & ~target_q);
    matched    = (acc == target_q);

    do_hit     = 1'b0;
    do_miss    = 1'b0;
`ifdef GHOST_PENALTY_EN
    ghost      = 1'b0;
`endif
    state_d    = state_q;
    target_d   = target_q;
    pressed_d  = pressed_q;

    // Judge the current note; a wrong lane wins over a completed match.
    if (state_q == WINDOW) begin
      if (wrong_lane) begin
        do_miss = 1'b1;
        state_d = JUDGED;
      end else if (matched) begin
        do_hit  = 1'b1;
        state_d = JUDGED;
      end else begin
        pressed_d = acc;
        if (tick) begin
          do_miss = 1'b1;
        end
      end
    end
`ifdef GHOST_PENALTY_EN
    else if (|new_press) begin
      do_miss = 1'b1;
      ghost   = 1'b1;
    end
`endif

    // The next note loads after the old one is judged; presses seen in
    // this cycle were already consumed by the old note.
    if (tick) begin
      target_d  = song_data;
      pressed_d = '0;
      state_d   = (|song_data) ? WINDOW : REST;
    end

    score_d = score_q;
    combo_d = combo_q;
    if (do_hit) begin
      score_d = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
      combo_d = (&combo_q) ? combo_q : combo_q + 1'b1;
    end else if (do_miss) begin
      combo_d = '0;
`ifdef GHOST_PENALTY_EN
      if (ghost) begin
        score_d = (score_q < SCORE_W'(POINTS_PER_HIT)) ? '0
                                                       : score_q - SCORE_W'(POINTS_PER_HIT);
      end
`endif
    end
    hit_d  = do_hit;
    miss_d = do_miss;

    if (clear) begin
      state_d   = REST;
      target_d  = '0;
      pressed_d = '0;
      score_d   = '0;
      combo_d   = '0;
      hit_d     = 1'b0;
      miss_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= REST;
      target_q  <= '0;
      pressed_q <= '0;
      btn_q     <= '0;
      score_q   <= '0;
      combo_q   <= '0;
      hit_q     <= 1'b0;
      miss_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      pressed_q <= pressed_d;
      btn_q     <= clear ? '0 : buttons;
      score_q   <= score_d;
      combo_q   <= combo_d;
      hit_q     <= hit_d;
      miss_q    <= miss_d;
    end
  end

  assign score = score_q;
  assign combo = combo_q;
  assign hit   = hit_q;
  assign miss  = miss_q;

endmodule

// File: tb/tb_score_tracker.sv
// Testbench for score_tracker (SCORE_W=8, COMBO_STEP=4, other defaults).
// A note-level reference model tracks the active note, the lanes pressed so
// far and whether the note has been scored, and predicts every output.

module tb_score_tracker;

  localparam int LANES = 4;
  localparam int SW    = 8;
  localparam int CW    = 8;
  localparam int PTS   = 10;
  localparam int STEP  = 4;
  localparam int MMAX  = 4;
  localparam int SMAX  = (1 << SW) - 1;
  localparam int CMAX  = (1 << CW) - 1;

  logic             clk;
  logic             rst_n;
  logic             tick;
  logic             clear;
  logic [LANES-1:0] buttons;
  logic [LANES-1:0] song_data;
  logic [SW-1:0]    score;
  logic [CW-1:0]    combo;
  logic [2:0]       multiplier;
  logic             hit;
  logic             miss;

  score_tracker #(
    .LANES(LANES), .SCORE_W(SW), .COMBO_W(CW),
    .POINTS_PER_HIT(PTS), .COMBO_STEP(STEP), .MAX_MULT(MMAX)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .clear(clear),
    .buttons(buttons), .song_data(song_data),
    .score(score), .combo(combo), .multiplier(multiplier),
    .hit(hit), .miss(miss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int               m_score;
  int               m_combo;
  logic [LANES-1:0] m_target;
  logic [LANES-1:0] m_pressed;
  logic [LANES-1:0] m_btn;
  bit               m_done;
  int               e_hit;
  int               e_miss;

  function automatic int mult_of(int c);
    int m;
    m = 1 + c / STEP;
    return (m > MMAX) ? MMAX : m;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_score = 0; m_combo = 0; m_target = '0; m_pressed = '0;
    m_btn = '0; m_done = 0; e_hit = 0; e_miss = 0;
  endtask

  task automatic model_step(input bit t, input logic [LANES-1:0] sd,
                            input logic [LANES-1:0] b, input bit c);
    logic [LANES-1:0] np;
    logic [LANES-1:0] acc;
    bit               ghost;
    e_hit = 0; e_miss = 0; ghost = 0;
    if (c) begin
      model_reset();
      return;
    end
    np  = b & ~m_btn;
    acc = m_pressed | np;
    if (m_target != 0 && !m_done) begin
      if ((acc & ~m_target) != 0)  e_miss = 1;
      else if (acc == m_target)    e_hit = 1;
      else if (t)                  e_miss = 1;
      else                         m_pressed = acc;
      if (e_hit == 1 || e_miss == 1) m_done = 1;
    end
`ifdef GHOST_PENALTY_EN
    else if (np != 0) begin
      e_miss = 1;
      ghost  = 1;
    end
`endif
    if (e_hit == 1) begin
      m_score = m_score + PTS * mult_of(m_combo);
      if (m_score > SMAX) m_score = SMAX;
      m_combo = (m_combo == CMAX) ? CMAX : m_combo + 1;
    end else if (e_miss == 1) begin
      m_combo = 0;
      if (ghost) m_score = (m_score < PTS) ? 0 : m_score - PTS;
    end
    if (t) begin
      m_target  = sd;
      m_pressed = '0;
      m_done    = 0;
    end
    m_btn = b;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".score"}, int'(score), m_score);
    chk({tag, ".combo"}, int'(combo), m_combo);
    chk({tag, ".mult"},  int'(multiplier), mult_of(m_combo));
    chk({tag, ".hit"},   int'(hit), e_hit);
    chk({tag, ".miss"},  int'(miss), e_miss);
  endtask

  // Drive one cycle of inputs, advance the model, check after the edge.
  task automatic cyc(input bit t, input logic [LANES-1:0] sd,
                     input logic [LANES-1:0] b, input bit c, input string tag);
    tick = t; song_data = sd; buttons = b; clear = c;
    model_step(t, sd, b, c);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [LANES-1:0] sd;
    logic [LANES-1:0] b;
    int               r;

    rst_n = 1'b0; tick = 1'b0; clear = 1'b0; buttons = '0; song_data = '0;
    model_reset();
    #1;
    check_all("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single note, then a held button across the next note which times out
    cyc(1, 4'b0010, 4'b0000, 0, "single_tick");
    cyc(0, 4'b0000, 4'b0000, 0, "single_w1");
    cyc(0, 4'b0000, 4'b0000, 0, "single_w2");
    cyc(0, 4'b0000, 4'b0010, 0, "single_press");
    chk("single_hit", int'(hit), 1);
    chk("single_score", int'(score), 10);
    cyc(1, 4'b0010, 4'b0010, 0, "held_tick");
    for (int i = 0; i < 3; i++) cyc(0, 4'b0000, 4'b0010, 0, "held");
    cyc(1, 4'b0000, 4'b0010, 0, "timeout");
    chk("timeout_miss", int'(miss), 1);
    chk("timeout_combo", int'(combo), 0);
    cyc(0, 4'b0000, 4'b0000, 0, "release");

    // Chord built from two presses, then a wrong-lane chord
    cyc(1, 4'b0101, 4'b0000, 0, "chord_tick");
    cyc(0, 4'b0000, 4'b0001, 0, "chord_p0");
    cyc(0, 4'b0000, 4'b0001, 0, "chord_hold");
    cyc(0, 4'b0000, 4'b0101, 0, "chord_p2");
    chk("chord_hit", int'(hit), 1);
    cyc(0, 4'b0000, 4'b0000, 0, "chord_rel");
    cyc(1, 4'b0101, 4'b0000, 0, "wrong_tick");
    cyc(0, 4'b0000, 4'b0111, 0, "wrong_press");
    chk("wrong_miss", int'(miss), 1);
    cyc(0, 4'b0000, 4'b0000, 0, "wrong_rel");
    cyc(0, 4'b0000, 4'b0101, 0, "late_press");
    chk("late_no_hit", int'(hit), 0);
    cyc(0, 4'b0000, 4'b0000, 0, "late_rel");

    // Correct press coincides with tick; the new note starts empty
    cyc(1, 4'b0100, 4'b0000, 0, "coll_tick1");
    cyc(0, 4'b0000, 4'b0000, 0, "coll_w");
    cyc(1, 4'b0001, 4'b0100, 0, "coll_tick2");
    chk("coll_old_hit", int'(hit), 1);
    cyc(0, 4'b0000, 4'b0101, 0, "coll_new");
    chk("coll_new_hit", int'(hit), 1);
    cyc(0, 4'b0000, 4'b0000, 0, "coll_rel");
    cyc(1, 4'b0000, 4'b0000, 0, "rest_tick");

    // Press during a rest (ghost note when the penalty is built in)
    cyc(0, 4'b0000, 4'b0010, 0, "ghost_press");
    cyc(0, 4'b0000, 4'b0000, 0, "ghost_rel");

    // Restart, then a streak of 20 hits through the multiplier steps
    cyc(0, 4'b0000, 4'b0000, 1, "clear");
    chk("clear_score", int'(score), 0);
    for (int i = 1; i <= 20; i++) begin
      sd = 4'($urandom_range(1, 15));
      cyc(1, sd, 4'b0000, 0, "streak_tick");
      cyc(0, 4'b0000, sd, 0, "streak_hit");
      cyc(0, 4'b0000, 4'b0000, 0, "streak_rel");
      if (i == 8) begin
        chk("streak8_score", int'(score), 120);
        chk("streak8_combo", int'(combo), 8);
      end
      if (i == 12) chk("streak12_mult", int'(multiplier), 4);
    end
    chk("streak20_combo", int'(combo), 20);
    chk("streak20_mult", int'(multiplier), 4);
    chk("streak20_score_sat", int'(score), 255);

    // Asynchronous reset mid-run takes effect without a clock edge
    cyc(1, 4'b0011, 4'b0000, 0, "pre_rst_tick");
    cyc(0, 4'b0000, 4'b0011, 0, "pre_rst_hit");
    rst_n = 1'b0;
    buttons = '0;
    model_reset();
    #1;
    check_all("async_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Randomised play
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 40)      b = '0;
      else if (r < 75) b = m_target | m_pressed;
      else             b = 4'($urandom_range(0, 15));
      sd = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      cyc(($urandom_range(0, 5) == 0), sd, b, ($urandom_range(0, 199) == 0), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
